pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 6-stage pipeline (IF, ID, RR, EX, MEM, WB).
- Drives write-enable and flush inputs of the IF/ID and ID/RR registers, inserts RR/EX bubbles, and redirects the PC.
- Resolves load-use hazards, taken branches in EX and jumps in ID.
- Sequences LM/SM (load/store-multiple) in RR as one micro-op per set mask bit.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clock  in  1  pipeline clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
rr_valid  in  1  RR stage holds a valid instruction.
rr_src1  in  3  RR source register 1.
rr_src2  in  3  RR source register 2.
rr_use  in  2  bit0: src1 read; bit1: src2 read.
rr_is_multi  in  1  RR instruction is LM/SM.
rr_reg_mask  in  8  LM/SM register mask; bit i = R i.
ex_valid  in  1  EX holds a valid instruction.
ex_is_load  in  1  EX instruction is a load.
ex_dest  in  3  EX destination register.
ex_br_taken  in  1  EX branch resolved taken; qualified by ex_valid.
ex_br_target  in  16  branch target.
id_jump  in  1  valid jump decoded in ID.
id_jump_target  in  16  jump target.
pc_write  out  1  PC update enable.
if_id_write  out  1  IF/ID load enable.
id_rr_write  out  1  ID/RR load enable.
if_id_flush  out  1  flush IF/ID (NOP 16'hFFFF, valid 0).
id_rr_flush  out  1  flush ID/RR.
rr_ex_bubble  out  1  load NOP into RR/EX instead of RR contents.
pc_redirect  out  1  PC takes pc_redirect_addr instead of PC+1.
pc_redirect_addr  out  16  redirect target.
multi_active  out  1  current RR issue is an LM/SM micro-op.
multi_reg  out  3  register index of current micro-op.
multi_offset  out  3  address offset (count of lower set bits already issued).
stall_count  out  STALL_CNT_W  cycles with pc_write=0, saturating.

Behaviour:
- FSM states: RUN, MULTI. State register and remaining mask `rem[7:0]` are held in flops. Control outputs are combinational from state, rem and inputs.
- Reset (reset_n=0, asynchronous):
  - Registered state: state=RUN, rem=0, stall_count=0.
  - Forced outputs: pc_write=if_id_write=id_rr_write=0, if_id_flush=id_rr_flush=rr_ex_bubble=1, pc_redirect=0, pc_redirect_addr=0, multi_*=0.
- Defaults (no event): all write enables 1, flushes/bubble/redirect 0.
- Priority: branch > load-use > multi hold > jump.
- Branch (ex_valid&ex_br_taken):
  - pc_write=1, pc_redirect=1, addr=ex_br_target.
  - if_id_flush=id_rr_flush=rr_ex_bubble=1.
  - In MULTI: abort, next state=RUN, rem=0.
  - id_jump ignored this cycle.
- Load-use (RUN only, rr_valid, ex_valid&ex_is_load, and (rr_use[0]&rr_src1==ex_dest | rr_use[1]&rr_src2==ex_dest)):
  - pc_write=if_id_write=id_rr_write=0, rr_ex_bubble=1.
  - Exactly 1 stall cycle; clears naturally when the bubble enters EX.
  - id_jump is suppressed while held; it fires on the release cycle.
- Multi sequencing (rr_valid&rr_is_multi, k = popcount(rr_reg_mask)):
  - RUN, k=0: no micro-op, multi_active=0, passes as NOP, no stall.
  - RUN, k>=1: issue lowest set bit, multi_offset=0, multi_active=1.
    - If k>1: hold PC/IF_ID/ID_RR (enables 0), rem=mask minus lowest bit, go to MULTI.
  - MULTI: issue lowest bit of rem, multi_offset = previous+1, and clear that bit.
    - Enables stay 0 unless it is the last bit of rem; on the last bit, enables=1 and next state=RUN.
  - Total k cycles, k-1 stall cycles; mask 8'hFF issues offsets 0..7.
  - No load-use check in MULTI: previous EX op belongs to the same instruction.
- Jump (id_jump, no higher event): pc_redirect=1, addr=id_jump_target, if_id_flush=1.
- stall_count: +1 each cycle pc_write=0 with reset_n=1; holds at all-ones.

Test Plan:
1. Load R3 in EX, RR reads src1=R3 with rr_use=01 -> one cycle with pc_write=0 and rr_ex_bubble=1; next cycle all enables 1; stall_count=1.
2. LM with mask 8'b1010_0100 in RR -> 3 cycles: multi_reg 2/5/7, offsets 0/1/2; enables 0,0,1; then state RUN.
3. Branch taken in EX (target 16'h0040) during MULTI cycle 2 of a mask 8'hFF SM -> pc_redirect=1, addr=0040, all flushes 1; next cycle multi_active=0.
4. Load-use hazard and id_jump (target 16'h0100) simultaneous -> jump held; next cycle pc_redirect=1, addr=0100, if_id_flush=1.
5. reset_n low mid-MULTI (mask 8'h0F, after 2 issues) -> state RUN and stall_count=0 immediately; flushes 1; after release, the first cycle is a normal RUN cycle.
6. Force 2^STALL_CNT_W+3 stall cycles (STALL_CNT_W=4, repeated multi 8'hFF) -> stall_count saturates at 4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline.
// Handles branches, load-use stalls, ID jumps and LM/SM micro-op issue.
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rr_valid,
    input  logic [2:0]             rr_src1,
    input  logic [2:0]             rr_src2,
    input  logic [1:0]             rr_use,
    input  logic                   rr_is_multi,
    input  logic [7:0]             rr_reg_mask,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic [2:0]             ex_dest,
    input  logic                   ex_br_taken,
    input  logic [15:0]            ex_br_target,
    input  logic                   id_jump,
    input  logic [15:0]            id_jump_target,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_rr_write,
    output logic                   if_id_flush,
    output logic                   id_rr_flush,
    output logic                   rr_ex_bubble,
    output logic                   pc_redirect,
    output logic [15:0]            pc_redirect_addr,
    output logic                   multi_active,
    output logic [2:0]             multi_reg,
    output logic [2:0]             multi_offset,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN,
        MULTI
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] rem;
    logic [7:0] rem_nx;
    logic [2:0] off_q;
    logic [2:0] off_nx;
    logic       branch;
    logic       load_use;
    logic       src_hit;
    logic       multi_start;
    logic       hold;

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    assign branch  = ex_valid & ex_br_taken;
    assign src_hit = (rr_use[0] & (rr_src1 == ex_dest))
                   | (rr_use[1] & (rr_src2 == ex_dest));
    assign load_use = (state == RUN) & rr_valid & ex_valid
                    & ex_is_load & src_hit;
    assign multi_start = (state == RUN) & rr_valid & rr_is_multi
                       & (|rr_reg_mask);

    always_comb begin
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        id_rr_write      = 1'b1;
        if_id_flush      = 1'b0;
        id_rr_flush      = 1'b0;
        rr_ex_bubble     = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = 16'h0000;
        multi_active     = 1'b0;
        multi_reg        = 3'd0;
        multi_offset     = 3'd0;
        hold             = 1'b0;
        state_nx         = state;
        rem_nx           = rem;
        off_nx           = off_q;
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_rr_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_rr_flush  = 1'b1;
            rr_ex_bubble = 1'b1;
            state_nx     = RUN;
            rem_nx       = 8'h00;
            off_nx       = 3'd0;
        end else if (branch) begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = ex_br_target;
            if_id_flush      = 1'b1;
            id_rr_flush      = 1'b1;
            rr_ex_bubble     = 1'b1;
            state_nx         = RUN;
            rem_nx           = 8'h00;
            off_nx           = 3'd0;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_rr_write  = 1'b0;
            rr_ex_bubble = 1'b1;
        end else begin
            if (state == MULTI) begin
                multi_active = 1'b1;
                multi_reg    = low_idx(rem);
                multi_offset = off_q + 3'd1;
                off_nx       = off_q + 3'd1;
                rem_nx       = rem & (rem - 8'd1);
                hold         = |rem_nx;
                if (!hold) state_nx = RUN;
            end else if (multi_start) begin
                multi_active = 1'b1;
                multi_reg    = low_idx(rr_reg_mask);
                multi_offset = 3'd0;
                off_nx       = 3'd0;
                rem_nx       = rr_reg_mask & (rr_reg_mask - 8'd1);
                hold         = |rem_nx;
                if (hold) state_nx = MULTI;
            end
            // a jump waits until RR stops holding the front end
            if (hold) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_rr_write = 1'b0;
            end else if (id_jump) begin
                pc_redirect      = 1'b1;
                pc_redirect_addr = id_jump_target;
                if_id_flush      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            rem         <= 8'h00;
            off_q       <= 3'd0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            off_q <= off_nx;
            if (!pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl.
// Expected values come from a queue-based model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int W = 4;
    localparam int CMAX = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         rr_valid;
    logic [2:0]   rr_src1;
    logic [2:0]   rr_src2;
    logic [1:0]   rr_use;
    logic         rr_is_multi;
    logic [7:0]   rr_reg_mask;
    logic         ex_valid;
    logic         ex_is_load;
    logic [2:0]   ex_dest;
    logic         ex_br_taken;
    logic [15:0]  ex_br_target;
    logic         id_jump;
    logic [15:0]  id_jump_target;
    logic         pc_write;
    logic         if_id_write;
    logic         id_rr_write;
    logic         if_id_flush;
    logic         id_rr_flush;
    logic         rr_ex_bubble;
    logic         pc_redirect;
    logic [15:0]  pc_redirect_addr;
    logic         multi_active;
    logic [2:0]   multi_reg;
    logic [2:0]   multi_offset;
    logic [W-1:0] stall_count;

    int n_pass = 0;
    int n_total = 0;

    int q[$];
    int nxt_off = 0;
    int cnt = 0;

    pipe_hazard_ctrl #(.STALL_CNT_W(W)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rr_valid(rr_valid),
        .rr_src1(rr_src1),
        .rr_src2(rr_src2),
        .rr_use(rr_use),
        .rr_is_multi(rr_is_multi),
        .rr_reg_mask(rr_reg_mask),
        .ex_valid(ex_valid),
        .ex_is_load(ex_is_load),
        .ex_dest(ex_dest),
        .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target),
        .id_jump(id_jump),
        .id_jump_target(id_jump_target),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_rr_write(id_rr_write),
        .if_id_flush(if_id_flush),
        .id_rr_flush(id_rr_flush),
        .rr_ex_bubble(rr_ex_bubble),
        .pc_redirect(pc_redirect),
        .pc_redirect_addr(pc_redirect_addr),
        .multi_active(multi_active),
        .multi_reg(multi_reg),
        .multi_offset(multi_offset),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        rr_valid       = 1'b0;
        rr_src1        = 3'd0;
        rr_src2        = 3'd0;
        rr_use         = 2'b00;
        rr_is_multi    = 1'b0;
        rr_reg_mask    = 8'h00;
        ex_valid       = 1'b0;
        ex_is_load     = 1'b0;
        ex_dest        = 3'd0;
        ex_br_taken    = 1'b0;
        ex_br_target   = 16'h0000;
        id_jump        = 1'b0;
        id_jump_target = 16'h0000;
    endtask

    task automatic model_clear();
        q.delete();
        nxt_off = 0;
        cnt = 0;
    endtask

    task automatic reset_check();
        chk("rst_pcw", 32'(pc_write), 32'd0);
        chk("rst_ifw", 32'(if_id_write), 32'd0);
        chk("rst_idw", 32'(id_rr_write), 32'd0);
        chk("rst_iff", 32'(if_id_flush), 32'd1);
        chk("rst_idf", 32'(id_rr_flush), 32'd1);
        chk("rst_bub", 32'(rr_ex_bubble), 32'd1);
        chk("rst_red", 32'(pc_redirect), 32'd0);
        chk("rst_addr", 32'(pc_redirect_addr), 32'd0);
        chk("rst_ma", 32'(multi_active), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
    endtask

    task automatic model_check();
        logic br, lu, hold;
        logic e_pcw, e_en, e_iff, e_idf, e_bub, e_red, e_ma;
        logic [15:0] e_addr;
        logic [2:0] e_mr, e_mo;
        br = ex_valid && ex_br_taken;
        lu = (q.size() == 0) && rr_valid && ex_valid && ex_is_load &&
             ((rr_use[0] && rr_src1 == ex_dest) ||
              (rr_use[1] && rr_src2 == ex_dest));
        e_pcw = 1; e_en = 1; e_iff = 0; e_idf = 0; e_bub = 0;
        e_red = 0; e_addr = 0; e_ma = 0; e_mr = 0; e_mo = 0;
        hold = 0;
        if (br) begin
            e_red = 1; e_addr = ex_br_target;
            e_iff = 1; e_idf = 1; e_bub = 1;
            q.delete();
        end else if (lu) begin
            e_pcw = 0; e_en = 0; e_bub = 1;
        end else begin
            if (q.size() > 0) begin
                e_ma = 1;
                e_mr = 3'(q.pop_front());
                e_mo = 3'(nxt_off);
                nxt_off++;
                hold = q.size() > 0;
            end else if (rr_valid && rr_is_multi && rr_reg_mask != 0) begin
                for (int i = 0; i < 8; i++) if (rr_reg_mask[i]) q.push_back(i);
                e_ma = 1;
                e_mr = 3'(q.pop_front());
                e_mo = 3'd0;
                nxt_off = 1;
                hold = q.size() > 0;
            end
            if (hold) begin
                e_pcw = 0; e_en = 0;
            end else if (id_jump) begin
                e_red = 1; e_addr = id_jump_target; e_iff = 1;
            end
        end
        chk("pc_write", 32'(pc_write), 32'(e_pcw));
        chk("if_id_write", 32'(if_id_write), 32'(e_en));
        chk("id_rr_write", 32'(id_rr_write), 32'(e_en));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        chk("id_rr_flush", 32'(id_rr_flush), 32'(e_idf));
        chk("rr_ex_bubble", 32'(rr_ex_bubble), 32'(e_bub));
        chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
        chk("redirect_addr", 32'(pc_redirect_addr), 32'(e_addr));
        chk("multi_active", 32'(multi_active), 32'(e_ma));
        chk("multi_reg", 32'(multi_reg), 32'(e_mr));
        chk("multi_offset", 32'(multi_offset), 32'(e_mo));
        chk("stall_count", 32'(stall_count), 32'(cnt));
        if (!e_pcw && cnt < CMAX) cnt++;
    endtask

    task automatic eval();
        #2;
        model_check();
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_check();
        model_clear();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int regs[3];
        int offs[3];
        int ens[3];
        regs = '{2, 5, 7};
        offs = '{0, 1, 2};
        ens  = '{0, 0, 1};
        idle();
        reset_n = 1'b1;
        tick();
        do_reset();

        // load-use single stall
        ex_valid = 1; ex_is_load = 1; ex_dest = 3'd3;
        rr_valid = 1; rr_src1 = 3'd3; rr_use = 2'b01;
        eval();
        chk("t1_pcw", 32'(pc_write), 32'd0);
        chk("t1_bub", 32'(rr_ex_bubble), 32'd1);
        tick();
        ex_valid = 0; ex_is_load = 0;
        eval();
        chk("t1_pcw2", 32'(pc_write), 32'd1);
        chk("t1_en", 32'(if_id_write & id_rr_write), 32'd1);
        chk("t1_cnt", 32'(stall_count), 32'd1);
        tick();

        // LM with mask A4
        idle();
        rr_valid = 1; rr_is_multi = 1; rr_reg_mask = 8'b1010_0100;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("t2_reg", 32'(multi_reg), 32'(regs[i]));
            chk("t2_off", 32'(multi_offset), 32'(offs[i]));
            chk("t2_en", 32'(pc_write), 32'(ens[i]));
            tick();
        end
        rr_valid = 0; rr_is_multi = 0;
        eval();
        chk("t2_run", 32'(multi_active), 32'd0);
        tick();

        // branch aborts an SM 8'hFF in its second cycle
        rr_valid = 1; rr_is_multi = 1; rr_reg_mask = 8'hFF;
        eval();
        tick();
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 16'h0040;
        eval();
        chk("t3_red", 32'(pc_redirect), 32'd1);
        chk("t3_addr", 32'(pc_redirect_addr), 32'h40);
        chk("t3_fl", 32'(if_id_flush & id_rr_flush & rr_ex_bubble), 32'd1);
        tick();
        idle();
        eval();
        chk("t3_ma", 32'(multi_active), 32'd0);
        tick();

        // jump held behind a load-use stall
        ex_valid = 1; ex_is_load = 1; ex_dest = 3'd5;
        rr_valid = 1; rr_src2 = 3'd5; rr_use = 2'b10;
        id_jump = 1; id_jump_target = 16'h0100;
        eval();
        chk("t4_held", 32'(pc_redirect), 32'd0);
        tick();
        ex_valid = 0; ex_is_load = 0;
        eval();
        chk("t4_red", 32'(pc_redirect), 32'd1);
        chk("t4_addr", 32'(pc_redirect_addr), 32'h100);
        chk("t4_iff", 32'(if_id_flush), 32'd1);
        tick();

        // reset in the middle of a multi
        idle();
        rr_valid = 1; rr_is_multi = 1; rr_reg_mask = 8'h0F;
        eval(); tick();
        eval(); tick();
        #3;
        reset_n = 1'b0;
        #1;
        reset_check();
        model_clear();
        tick();
        reset_n = 1'b1;
        eval();
        chk("t5_reg", 32'(multi_reg), 32'd0);
        chk("t5_off", 32'(multi_offset), 32'd0);
        tick();
        idle();
        eval(); tick();

        // counter saturation
        rr_valid = 1; rr_is_multi = 1; rr_reg_mask = 8'hFF;
        for (int i = 0; i < 32; i++) begin
            eval(); tick();
        end
        idle();
        eval();
        chk("t6_sat", 32'(stall_count), 32'hF);
        tick();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 120) == 0) do_reset();
            rr_valid       = $urandom_range(0, 3) != 0;
            rr_src1        = 3'($urandom_range(0, 7));
            rr_src2        = 3'($urandom_range(0, 7));
            rr_use         = 2'($urandom_range(0, 3));
            rr_is_multi    = $urandom_range(0, 3) == 0;
            case ($urandom_range(0, 5))
                0: rr_reg_mask = 8'h00;
                1: rr_reg_mask = 8'hFF;
                default: rr_reg_mask = 8'($urandom);
            endcase
            ex_valid       = $urandom_range(0, 2) != 0;
            ex_is_load     = $urandom_range(0, 1) == 1;
            ex_dest        = $urandom_range(0, 1) == 1 ? rr_src1
                                                       : 3'($urandom_range(0, 7));
            ex_br_taken    = $urandom_range(0, 9) == 0;
            ex_br_target   = 16'($urandom);
            id_jump        = $urandom_range(0, 4) == 0;
            id_jump_target = 16'($urandom);
            eval();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
